// File: rtl/mem_port_arbiter_if.sv
// Request/grant bundle between the arbiter, both cache refill engines, the DMA bus request and the memory port.
// "master" is the arbiter side, "slave" is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 16
) ();
  logic                 i_req;
  logic [WORD_SIZE-1:0] i_addr;
  logic                 i_done;
  logic                 d_req;
  logic                 d_we;
  logic [WORD_SIZE-1:0] d_addr;
  logic                 d_done;
  logic                 dma_br;
  logic                 dma_bg;
  logic                 mem_req;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_addr;
  logic                 mem_done;
  logic                 busy;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, dma_br, mem_done,
    output i_done, d_done, dma_bg, mem_req, mem_we, mem_addr, busy
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, dma_br, mem_done,
    input  i_done, d_done, dma_bg, mem_req, mem_we, mem_addr, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fixed-priority owner of the single memory port: D refill/writeback > I refill > DMA; 2-cycle grant, 1-cycle done, one TURN cycle between owners.
// `DMA_STARVE_GUARD_EN adds a saturating counter that promotes DMA to top priority after DMA_WAIT_MAX denied IDLE cycles.
module mem_port_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int DMA_WAIT_MAX = 8
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master io_bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GNT_D   = 3'd1,
    GNT_I   = 3'd2,
    GNT_DMA = 3'd3,
    TURN    = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [WORD_SIZE-1:0] r_mem_addr;
  logic                 r_dma_bg;
  logic                 r_i_done;
  logic                 r_d_done;
  logic                 r_busy;

  logic w_cpu_req;
  logic w_force_dma;
  logic w_pick_dma;
  logic w_pick_d;
  logic w_pick_i;

  assign w_cpu_req = io_bus.d_req | io_bus.i_req;

`ifdef DMA_STARVE_GUARD_EN
  localparam int CW = $clog2(DMA_WAIT_MAX + 1);
  logic [CW-1:0] r_wait_cnt;

  assign w_force_dma = io_bus.dma_br && (r_wait_cnt >= CW'(DMA_WAIT_MAX));

  // Counts only arbitrations DMA lost to a CPU requester; any DMA win clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_pick_dma) begin
        r_wait_cnt <= '0;
      end else if (io_bus.dma_br && w_cpu_req && (r_wait_cnt < CW'(DMA_WAIT_MAX))) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end
`else
  logic w_unused_wait_max;
  assign w_force_dma       = 1'b0;
  assign w_unused_wait_max = ^DMA_WAIT_MAX;
`endif

  assign w_pick_dma = w_force_dma | (io_bus.dma_br & ~w_cpu_req);
  assign w_pick_d   = ~w_force_dma & io_bus.d_req;
  assign w_pick_i   = ~w_force_dma & ~io_bus.d_req & io_bus.i_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_dma_bg   <= 1'b0;
      r_i_done   <= 1'b0;
      r_d_done   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // Address/we are latched here so later requester changes cannot disturb the burst.
          if (w_pick_dma) begin
            r_state <= GNT_DMA;
            r_busy  <= 1'b1;
          end else if (w_pick_d) begin
            r_state    <= GNT_D;
            r_mem_addr <= io_bus.d_addr;
            r_mem_we   <= io_bus.d_we;
            r_busy     <= 1'b1;
          end else if (w_pick_i) begin
            r_state    <= GNT_I;
            r_mem_addr <= io_bus.i_addr;
            r_mem_we   <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        GNT_D, GNT_I: begin
          if (!r_mem_req) begin
            r_mem_req <= 1'b1;
          end else if (io_bus.mem_done) begin
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_d_done   <= (r_state == GNT_D);
            r_i_done   <= (r_state == GNT_I);
            r_state    <= TURN;
          end
        end
        GNT_DMA: begin
          if (!io_bus.dma_br) begin
            r_dma_bg <= 1'b0;
            r_state  <= TURN;
          end else begin
            r_dma_bg <= 1'b1;
          end
        end
        TURN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_mem_req  <= 1'b0;
          r_mem_we   <= 1'b0;
          r_mem_addr <= '0;
          r_dma_bg   <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.mem_req  = r_mem_req;
  assign io_bus.mem_we   = r_mem_we;
  assign io_bus.mem_addr = r_mem_addr;
  assign io_bus.dma_bg   = r_dma_bg;
  assign io_bus.i_done   = r_i_done;
  assign io_bus.d_done   = r_d_done;
  assign io_bus.busy     = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants are queued as requests are raised and checked as the memory port is granted.
module tb_mem_port_arbiter;

`ifdef DMA_STARVE_GUARD_EN
  localparam int WAIT_MAX = 2;
`else
  localparam int WAIT_MAX = 8;
`endif

  typedef struct {
    logic        is_d;
    logic        we;
    logic [15:0] addr;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   dma_seen;
  logic mon_on;
  exp_t sb[$];

  mem_port_arbiter_if #(.WORD_SIZE(16)) bus ();

  mem_port_arbiter #(
    .WORD_SIZE   (16),
    .DMA_WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (mon_on && bus.dma_bg) dma_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic is_d, input logic we, input logic [15:0] addr);
    exp_t e;
    e.is_d = is_d;
    e.we   = we;
    e.addr = addr;
    sb.push_back(e);
  endtask

  // Waits for mem_req, checks it against the oldest expected grant, holds the burst for lat cycles, then completes it.
  task automatic serve(input int lat, input int exp_lat);
    exp_t e;
    int   n;
    n = 0;
    while (!bus.mem_req && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) check("done_width", {30'd0, bus.i_done, bus.d_done}, 32'd0);
    end
    if (!bus.mem_req) begin
      check("grant_timeout", bus.mem_req, 1);
      return;
    end
    if (exp_lat >= 0) check("grant_lat", n, exp_lat);
    if (sb.size() == 0) begin
      check("sb_underflow", sb.size(), 1);
      return;
    end
    e = sb.pop_front();
    check("gnt_addr", bus.mem_addr, e.addr);
    check("gnt_we", bus.mem_we, e.we);
    check("gnt_busy", bus.busy, 1);
    if (e.is_d) begin
      bus.d_addr = ~e.addr;
      bus.d_we   = ~e.we;
    end else begin
      bus.i_addr = ~e.addr;
    end
    repeat (lat - 1) @(negedge clk);
    check("hold_req", bus.mem_req, 1);
    check("hold_addr", bus.mem_addr, e.addr);
    check("hold_we", bus.mem_we, e.we);
    bus.mem_done = 1'b1;
    @(negedge clk);
    bus.mem_done = 1'b0;
    check("done_req", bus.mem_req, 0);
    check("done_addr", bus.mem_addr, 0);
    check("d_done", bus.d_done, e.is_d);
    check("i_done", bus.i_done, !e.is_d);
    check("done_busy", bus.busy, 1);
    if (e.is_d) bus.d_req = 1'b0;
    else        bus.i_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    dma_seen     = 0;
    mon_on       = 1'b0;
    reset        = 1'b1;
    bus.d_req    = 1'b1;
    bus.i_req    = 1'b1;
    bus.dma_br   = 1'b1;
    bus.d_we     = 1'b0;
    bus.d_addr   = 16'h0ABC;
    bus.i_addr   = 16'h0555;
    bus.mem_done = 1'b0;

    // Reset with every requester active: everything stays quiet.
    repeat (2) @(negedge clk);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_dma_bg", bus.dma_bg, 0);
    check("rst_dones", {30'd0, bus.i_done, bus.d_done}, 0);
    check("rst_busy", bus.busy, 0);
    push_exp(1'b1, 1'b0, 16'h0ABC);
    reset      = 1'b0;
    bus.i_req  = 1'b0;
    bus.dma_br = 1'b0;
    @(negedge clk);
    check("rel_early_req", bus.mem_req, 0);
    @(negedge clk);
    check("rel_req", bus.mem_req, 1);
    serve(4, 0);

    // Single I refill.
    repeat (2) @(negedge clk);
    bus.i_addr = 16'h0040;
    push_exp(1'b0, 1'b0, 16'h0040);
    bus.i_req = 1'b1;
    serve(4, 2);
    @(negedge clk);
    check("i_done_width", bus.i_done, 0);
    check("i_idle_busy", bus.busy, 0);

    // D and I together: D writeback first, I three cycles after d_done.
    repeat (2) @(negedge clk);
    bus.d_we   = 1'b1;
    bus.d_addr = 16'h1230;
    bus.i_addr = 16'h0080;
    push_exp(1'b1, 1'b1, 16'h1230);
    push_exp(1'b0, 1'b0, 16'h0080);
    bus.d_req = 1'b1;
    bus.i_req = 1'b1;
    serve(4, 2);
    serve(3, 3);
    @(negedge clk);
    check("sim_idle_busy", bus.busy, 0);

    // DMA grant, CPU request waits without preemption.
    repeat (2) @(negedge clk);
    bus.dma_br = 1'b1;
    @(negedge clk);
    check("dma_bg_early", bus.dma_bg, 0);
    check("dma_busy", bus.busy, 1);
    @(negedge clk);
    check("dma_bg", bus.dma_bg, 1);
    check("dma_mem_req", bus.mem_req, 0);
    bus.i_addr = 16'h0100;
    push_exp(1'b0, 1'b0, 16'h0100);
    bus.i_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("dma_hold_req", bus.mem_req, 0);
      check("dma_hold_bg", bus.dma_bg, 1);
    end
    bus.dma_br = 1'b0;
    @(negedge clk);
    check("dma_release", bus.dma_bg, 0);
    check("dma_turn_busy", bus.busy, 1);
    serve(3, 3);

    // Continuous alternating cache misses with DMA pending.
    repeat (2) @(negedge clk);
    bus.dma_br = 1'b1;
    mon_on     = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        bus.d_we   = 1'b0;
        bus.d_addr = 16'h2000 + 16'(k);
        push_exp(1'b1, 1'b0, 16'h2000 + 16'(k));
        bus.d_req = 1'b1;
      end else begin
        bus.i_addr = 16'h3000 + 16'(k);
        push_exp(1'b0, 1'b0, 16'h3000 + 16'(k));
        bus.i_req = 1'b1;
      end
`ifdef DMA_STARVE_GUARD_EN
      if (k == 2) begin
        int n;
        n = 0;
        while (!bus.dma_bg && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("starve_bg", bus.dma_bg, 1);
        check("starve_mem_req", bus.mem_req, 0);
        bus.dma_br = 1'b0;
      end
`endif
      serve(3, -1);
    end
    bus.dma_br = 1'b0;
    mon_on     = 1'b0;
`ifdef DMA_STARVE_GUARD_EN
    check("dma_served", dma_seen != 0, 1);
`else
    check("dma_starved", dma_seen, 0);
`endif

    // Reset in the middle of a D transaction; the late mem_done must not complete it.
    repeat (3) @(negedge clk);
    bus.d_addr = 16'h0777;
    bus.d_req  = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_req", bus.mem_req, 1);
    reset     = 1'b1;
    bus.d_req = 1'b0;
    @(negedge clk);
    check("mid_rst_req", bus.mem_req, 0);
    check("mid_rst_addr", bus.mem_addr, 0);
    check("mid_rst_busy", bus.busy, 0);
    reset        = 1'b0;
    bus.mem_done = 1'b1;
    @(negedge clk);
    bus.mem_done = 1'b0;
    check("mid_d_done", bus.d_done, 0);
    @(negedge clk);
    check("mid_d_done2", bus.d_done, 0);
    check("mid_busy", bus.busy, 0);
    check("sb_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
